// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: ID-stage lookup, EX-stage
// misprediction detection/redirect, table training and saturating statistics.
module branch_predictor #(
  parameter int PC_W     = 16,
  parameter int IDX_BITS = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              id_is_branch,
  output logic              prediction,
  output logic [PC_W-1:0]   pred_target,
  input  logic              ex_br_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mis_count
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = PC_W - IDX_BITS;

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [PC_W-1:0]   target_d [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [1:0]        ctr_d    [ENTRIES];
  logic [STAT_W-1:0] br_count_q, br_count_d;
  logic [STAT_W-1:0] mis_count_q, mis_count_d;

  logic [IDX_BITS-1:0] id_idx, ex_idx;
  logic [TAG_W-1:0]    id_tag, ex_tag;
  logic                id_hit, ex_hit, upd;

  assign id_idx = id_pc[IDX_BITS-1:0];
  assign id_tag = id_pc[PC_W-1:IDX_BITS];
  assign ex_idx = ex_pc[IDX_BITS-1:0];
  assign ex_tag = ex_pc[PC_W-1:IDX_BITS];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign id_hit      = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
  assign prediction  = id_is_branch && id_hit && ctr_q[id_idx][1] && !freeze;
  assign pred_target = target_q[id_idx];

  assign mispredict  = ex_br_valid &&
                       ((ex_taken != ex_pred_taken) ||
                        (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_W'(1);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd    = ex_br_valid && !freeze;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
    end
    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;

    if (upd) begin
      if (ex_hit) begin
        if (ex_taken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
          target_d[ex_idx] = ex_target;
        end else if (ctr_q[ex_idx] != 2'b00) begin
          ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        // Taken miss evicts whatever shares the index; start at weak-taken.
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = 2'b10;
      end

      if (br_count_q != '1) br_count_d = br_count_q + STAT_W'(1);
      if (mispredict && (mis_count_q != '1)) mis_count_d = mis_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign br_count  = br_count_q;
  assign mis_count = mis_count_q;
endmodule
